// File: rtl/my_isolation_ctrl.sv
// Sequenced multi-lane operand-isolation controller: per-lane ISO/WAKE/OPEN FSM with wake delay and global force clamp.
// Optional MY_ISOLATION_HOLD_EN: clamp to the last passed value instead of zero.
module my_isolation_ctrl #(
    parameter int ISOLATION_DATA_WIDTH = 32,
    parameter int NUM_CHANNELS         = 4,
    parameter int WAKE_CYCLES          = 2
) (
    input  logic                                         iClk,
    input  logic                                         iReset,
    input  logic [NUM_CHANNELS*ISOLATION_DATA_WIDTH-1:0] iData_In,
    input  logic [NUM_CHANNELS-1:0]                      iChan_Enable,
    input  logic                                         iForce_Iso,
    output logic [NUM_CHANNELS*ISOLATION_DATA_WIDTH-1:0] oIsolated_Out,
    output logic [NUM_CHANNELS-1:0]                      oChan_Open,
    output logic                                         oAll_Iso
);

    localparam int W     = ISOLATION_DATA_WIDTH;
    localparam int CNT_W = (WAKE_CYCLES > 0) ? $clog2(WAKE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = (WAKE_CYCLES > 0) ? CNT_W'(WAKE_CYCLES - 1) : CNT_W'(0);

    typedef enum logic [1:0] {
        ISO  = 2'd0,
        WAKE = 2'd1,
        OPEN = 2'd2
    } laneState_t;

    logic [NUM_CHANNELS-1:0] laneIso_s;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : gLane
        laneState_t     state_r;
        laneState_t     nextState_s;
        logic [CNT_W-1:0] cnt_r;
        logic [CNT_W-1:0] nextCnt_s;
        logic           laneEn_s;
        logic           pass_s;
        logic [W-1:0]   clamp_s;

        assign laneEn_s = iChan_Enable[c];
        // Force gates the data path directly so the clamp does not wait for the FSM
        assign pass_s   = (state_r == OPEN) && !iForce_Iso;

        // Lane state and settle counter
        always_ff @(posedge iClk or posedge iReset) begin
            if (iReset) begin
                state_r <= ISO;
                cnt_r   <= CNT_ZERO;
            end else begin
                state_r <= nextState_s;
                cnt_r   <= nextCnt_s;
            end
        end

        // Lane next-state: release only after WAKE_CYCLES+1 consecutive enabled samples
        always_comb begin
            nextState_s = state_r;
            nextCnt_s   = cnt_r;
            case (state_r)
                ISO: begin
                    if (laneEn_s && !iForce_Iso) begin
                        if (WAKE_CYCLES == 0) begin
                            nextState_s = OPEN;
                        end else begin
                            nextState_s = WAKE;
                            nextCnt_s   = WAKE_LOAD;
                        end
                    end else begin
                        nextState_s = ISO;
                    end
                end
                WAKE: begin
                    if (iForce_Iso || !laneEn_s) begin
                        nextState_s = ISO;
                        nextCnt_s   = CNT_ZERO;
                    end else if (cnt_r == CNT_ZERO) begin
                        nextState_s = OPEN;
                    end else begin
                        nextCnt_s = cnt_r - CNT_ONE;
                    end
                end
                OPEN: begin
                    if (iForce_Iso || !laneEn_s) begin
                        nextState_s = ISO;
                    end else begin
                        nextState_s = OPEN;
                    end
                end
                default: begin
                    nextState_s = ISO;
                    nextCnt_s   = CNT_ZERO;
                end
            endcase
        end

`ifdef MY_ISOLATION_HOLD_EN
        logic [W-1:0] hold_r;

        // Capture every value actually passed so the clamp repeats the last one
        always_ff @(posedge iClk or posedge iReset) begin
            if (iReset) begin
                hold_r <= {W{1'b0}};
            end else if (pass_s) begin
                hold_r <= iData_In[c*W +: W];
            end else begin
                hold_r <= hold_r;
            end
        end

        assign clamp_s = hold_r;
`else
        assign clamp_s = {W{1'b0}};
`endif

        assign oIsolated_Out[c*W +: W] = pass_s ? iData_In[c*W +: W] : clamp_s;
        assign oChan_Open[c]           = (state_r == OPEN);
        assign laneIso_s[c]            = (state_r == ISO);
    end

    assign oAll_Iso = &laneIso_s;

endmodule

// File: tb/tb_my_isolation_ctrl.sv
// Self-checking bench for my_isolation_ctrl: directed scenarios plus random stimulus against a streak-count reference model.
// Two DUTs share inputs: WAKE_CYCLES=2 and WAKE_CYCLES=0.
module tb_my_isolation_ctrl;
    localparam int W = 32;
    localparam int N = 4;

    logic           iClk = 1'b0;
    logic           iReset;
    logic           iForce_Iso;
    logic [N*W-1:0] iData_In;
    logic [N-1:0]   iChan_Enable;
    logic [N*W-1:0] outA, outB;
    logic [N-1:0]   openA, openB;
    logic           allIsoA, allIsoB;

    always #5 iClk = ~iClk;

    my_isolation_ctrl #(.ISOLATION_DATA_WIDTH(W), .NUM_CHANNELS(N), .WAKE_CYCLES(2)) dutA (
        .iClk(iClk), .iReset(iReset), .iData_In(iData_In), .iChan_Enable(iChan_Enable),
        .iForce_Iso(iForce_Iso), .oIsolated_Out(outA), .oChan_Open(openA), .oAll_Iso(allIsoA));

    my_isolation_ctrl #(.ISOLATION_DATA_WIDTH(W), .NUM_CHANNELS(N), .WAKE_CYCLES(0)) dutB (
        .iClk(iClk), .iReset(iReset), .iData_In(iData_In), .iChan_Enable(iChan_Enable),
        .iForce_Iso(iForce_Iso), .oIsolated_Out(outB), .oChan_Open(openB), .oAll_Iso(allIsoB));

    int errCount   = 0;
    int checkCount = 0;

    // Reference: a lane is open once it has seen WAKE+1 consecutive edges with enable high and no force.
    int           streak [2][N];
    logic [W-1:0] hold   [2][N];
    int           wakeOf [2] = '{2, 0};

    task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] clampOf(input int k, input int c);
`ifdef MY_ISOLATION_HOLD_EN
        return hold[k][c];
`else
        return {W{1'b0}};
`endif
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < N; c++) begin
                streak[k][c] = 0;
                hold[k][c]   = {W{1'b0}};
            end
    endtask

    task automatic modelEdge();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < N; c++) begin
                if (streak[k][c] > wakeOf[k] && !iForce_Iso) hold[k][c] = iData_In[c*W +: W];
                if (iChan_Enable[c] && !iForce_Iso) begin
                    if (streak[k][c] < 1000) streak[k][c]++;
                end else begin
                    streak[k][c] = 0;
                end
            end
    endtask

    task automatic checkAll(input string ph);
        for (int k = 0; k < 2; k++) begin
            logic [N*W-1:0] expOut;
            logic [N-1:0]   expOpen;
            logic           expAll;
            expAll = 1'b1;
            for (int c = 0; c < N; c++) begin
                expOpen[c] = (streak[k][c] > wakeOf[k]);
                if (streak[k][c] != 0) expAll = 1'b0;
                if (expOpen[c] && !iForce_Iso) expOut[c*W +: W] = iData_In[c*W +: W];
                else                           expOut[c*W +: W] = clampOf(k, c);
            end
            checkEq($sformatf("%s dut%0d out", ph, k), (k == 0) ? outA : outB, expOut);
            checkEq($sformatf("%s dut%0d open", ph, k), (k == 0) ? openA : openB, expOpen);
            checkEq($sformatf("%s dut%0d allIso", ph, k), (k == 0) ? allIsoA : allIsoB, expAll);
        end
    endtask

    task automatic drive(input logic [N-1:0] en, input logic frc, input logic [N*W-1:0] data);
        iChan_Enable = en;
        iForce_Iso   = frc;
        iData_In     = data;
        #1;
        checkAll("comb");
    endtask

    task automatic cycle();
        @(posedge iClk);
        if (!iReset) modelEdge();
        #1;
        checkAll("edge");
    endtask

    task automatic applyReset();
        iReset = 1'b1;
        modelReset();
        #1;
        checkAll("reset");
        cycle();
        iReset = 1'b0;
        #1;
    endtask

    logic [N*W-1:0] rnd;

    initial begin
        iReset       = 1'b1;
        iForce_Iso   = 1'b0;
        iChan_Enable = 4'b0000;
        iData_In     = {4{32'hDEADBEEF}};
        modelReset();
        #2;
        checkEq("rst out", outA, 128'd0);
        checkEq("rst open", openA, 128'd0);
        checkEq("rst allIso", allIsoA, 128'd1);
        checkAll("reset");
        cycle();
        cycle();
        iReset = 1'b0;
        #1;

        // Wake delay on lane 1
        drive(4'b0010, 1'b0, {32'h0, 32'h0, 32'h12345678, 32'h0});
        cycle();
        checkEq("wake e0 openA", openA, 128'h0);
        checkEq("wake e0 openB", openB, 128'h2);
        checkEq("wake e0 outB1", outB[63:32], 128'h12345678);
        cycle();
        checkEq("wake e1 openA", openA, 128'h0);
        checkEq("wake e1 outA1", outA[63:32], 128'h0);
        cycle();
        checkEq("wake e2 openA", openA, 128'h2);
        checkEq("wake e2 allIsoA", allIsoA, 128'h0);
        checkEq("wake e2 outA1", outA[63:32], 128'h12345678);

        // Reset asserted mid-OPEN clamps without a clock edge
        iReset = 1'b1;
        modelReset();
        #1;
        checkEq("midrst outA", outA, 128'h0);
        checkEq("midrst openA", openA, 128'h0);
        checkAll("midrst");
        cycle();
        iReset = 1'b0;
        #1;

        // Abort: lane 0 high one cycle, low, then high again
        drive(4'b0001, 1'b0, {4{32'hCAFEF00D}});
        cycle();
        drive(4'b0000, 1'b0, {4{32'hCAFEF00D}});
        cycle();
        checkEq("abort low", openA[0], 128'h0);
        drive(4'b0001, 1'b0, {4{32'hCAFEF00D}});
        cycle();
        cycle();
        checkEq("abort e1", openA[0], 128'h0);
        cycle();
        checkEq("abort e2", openA[0], 128'h1);

        // Force override with all lanes open
        drive(4'b1111, 1'b0, {4{32'h5A5A0001}});
        repeat (3) cycle();
        checkEq("all open", openA, 128'hF);
        drive(4'b1111, 1'b1, {4{32'h5A5A0002}});
        checkEq("force open unchanged", openA, 128'hF);
`ifndef MY_ISOLATION_HOLD_EN
        checkEq("force clamp", outA, 128'h0);
`endif
        cycle();
        checkEq("force iso", openA, 128'h0);
        checkEq("force allIso", allIsoA, 128'h1);
        drive(4'b1111, 1'b0, {4{32'h5A5A0003}});
        cycle();
        cycle();
        checkEq("reopen e1", openA, 128'h0);
        cycle();
        checkEq("reopen e2", openA, 128'hF);

        // Force together with a fresh enable
        drive(4'b0000, 1'b0, {4{32'h0}});
        cycle();
        drive(4'b0100, 1'b1, {4{32'h77777777}});
        cycle();
        checkEq("force+en openB", openB, 128'h0);
        checkEq("force+en allIsoA", allIsoA, 128'h1);

        // Hold behaviour on lane 2
        drive(4'b0100, 1'b0, {32'h0, 32'hA5A5A5A5, 32'h0, 32'h0});
        repeat (3) cycle();
        drive(4'b0100, 1'b0, {32'h0, 32'h0000FFFF, 32'h0, 32'h0});
        cycle();
        drive(4'b0000, 1'b0, {32'h0, 32'h0000FFFF, 32'h0, 32'h0});
        cycle();
        drive(4'b0000, 1'b0, {32'h0, 32'h11111111, 32'h0, 32'h0});
`ifdef MY_ISOLATION_HOLD_EN
        checkEq("hold lane2", outA[95:64], 128'h0000FFFF);
`else
        checkEq("hold lane2", outA[95:64], 128'h0);
`endif

        // Independence: lanes 0 and 3 staggered by one cycle
        drive(4'b0000, 1'b0, {4{32'h13572468}});
        cycle();
        drive(4'b0001, 1'b0, {4{32'h13572468}});
        cycle();
        drive(4'b1001, 1'b0, {4{32'h13572468}});
        cycle();
        cycle();
        checkEq("stagger a", openA, 128'h1);
        cycle();
        checkEq("stagger b", openA, 128'h9);
        checkEq("stagger lanes12", outA[95:32], 128'h0);

        // Random stimulus, enables biased to persist so lanes do open
        for (int i = 0; i < 800; i++) begin
            logic [N-1:0] en;
            en = iChan_Enable;
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 5) == 0) en[c] = ~en[c];
            rnd = {$urandom, $urandom, $urandom, $urandom};
            drive(en, ($urandom_range(0, 15) == 0), rnd);
            if ($urandom_range(0, 199) == 0) applyReset();
            else cycle();
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
